// File: rtl/wfifo_wr_arb.sv
// wfifo_wr_arb: round-robin burst arbiter sharing the async FIFO write port among NREQ requesters
module wfifo_wr_arb #(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*DSIZE-1:0] din,
    input  logic                  wfull,
    input  logic                  wfull_almost,
    output logic [NREQ-1:0]       gnt,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  busy
);
    localparam int OW = $clog2(NREQ);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state;
    logic [OW-1:0] owner, ptr, win, idx, nxt;
    logic [3:0]    cnt;
    logic          done;
    // Scan from ptr upwards; iterating downwards lets the nearest requester win.
    always_comb begin
        win = ptr;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = OW'((int'(ptr) + k) % NREQ);
            if (req[idx]) win = idx;
        end
    end
    assign nxt   = OW'((int'(owner) + 1) % NREQ);
    assign busy  = (state == GRANT);
    assign winc  = busy && req[owner] && !wfull;
    assign wdata = busy ? din[int'(owner)*DSIZE +: DSIZE] : '0;
    assign done  = (winc && (last[owner] || cnt + 4'd1 == 4'(MAXBURST))) || !req[owner];
    always_ff @(posedge wclk or negedge wrst_n)
        if (!wrst_n) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (|req && !wfull && !wfull_almost) begin
                state <= GRANT;
                owner <= win;
                gnt   <= NREQ'(1) << win;
                cnt   <= '0;
            end
        end else if (done) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= nxt;
            cnt   <= '0;
        end else if (winc) begin
            cnt <= cnt + 4'd1;
        end
endmodule

// File: tb/tb_wfifo_wr_arb.sv
// tb_wfifo_wr_arb: randomized scenario bench for wfifo_wr_arb with a behavioural queue-based model
module tb_wfifo_wr_arb;
    localparam int NREQ = 4, DSIZE = 8, MAXBURST = 4, QD = 128;
    logic wclk = 1'b0, wrst_n = 1'b0;
    logic [NREQ-1:0] req = '0, last = '0;
    logic [NREQ*DSIZE-1:0] din = '0;
    logic wfull = 1'b0, wfull_almost = 1'b0;
    logic [NREQ-1:0] gnt;
    logic winc, busy;
    logic [DSIZE-1:0] wdata;

    wfifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .last(last), .din(din),
        .wfull(wfull), .wfull_almost(wfull_almost),
        .gnt(gnt), .winc(winc), .wdata(wdata), .busy(busy)
    );

    always #5 wclk = ~wclk;

    int total = 0, bad = 0;
    logic [DSIZE:0] qm [NREQ][QD];
    int qh [NREQ], qt [NREQ];
    bit m_busy;
    int m_owner, m_ptr, m_cnt;
    logic [NREQ-1:0] exp_gnt, obs_gnt;
    logic exp_winc, obs_winc, exp_busy, obs_busy;
    logic [DSIZE-1:0] exp_wdata, obs_wdata;
    bit prev_busy;
    logic [NREQ-1:0] gq [$];
    logic [DSIZE-1:0] wq [$];
    int nwr;

    function automatic bit pending(input int r);
        return qh[r] != qt[r];
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < NREQ; i++) if (pending(i)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input int r, input logic [DSIZE-1:0] d, input logic l);
        qm[r][qt[r]] = {l, d};
        qt[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = pending(i);
            {last[i], din[i*DSIZE +: DSIZE]} = pending(i) ? qm[i][qh[i]] : '0;
        end
    endtask

    // One clock: drive requesters, sample DUT and model, then advance the model by the spec rules.
    task automatic step();
        int w;
        drive();
        #2;
        obs_gnt = gnt; obs_winc = winc; obs_busy = busy; obs_wdata = wdata;
        exp_busy  = m_busy;
        exp_gnt   = m_busy ? NREQ'(1) << m_owner : '0;
        exp_winc  = m_busy && req[m_owner] && !wfull;
        exp_wdata = m_busy ? din[m_owner*DSIZE +: DSIZE] : '0;
        if (obs_busy && !prev_busy) gq.push_back(obs_gnt);
        prev_busy = obs_busy;
        if (obs_winc) begin
            wq.push_back(obs_wdata);
            nwr++;
        end
        @(posedge wclk);
        if (!m_busy) begin
            if (req != '0 && !wfull && !wfull_almost) begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                m_busy = 1'b1; m_owner = w; m_cnt = 0;
            end
        end else begin
            if (exp_winc) begin
                m_cnt++;
                qh[m_owner]++;
            end
            if ((exp_winc && (last[m_owner] || m_cnt == MAXBURST)) || !req[m_owner]) begin
                m_busy = 1'b0; m_ptr = (m_owner + 1) % NREQ; m_cnt = 0;
            end
        end
        @(negedge wclk);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; prev_busy = 1'b0;
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        wfull = 1'b0; wfull_almost = 1'b0;
        for (int i = 0; i < NREQ; i++) begin qh[i] = 0; qt[i] = 0; end
        drive();
        gq.delete(); wq.delete(); nwr = 0;
        model_reset();
        @(negedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if ({obs_gnt, obs_winc, obs_busy, obs_wdata} !== {4'b0000, 1'b0, 1'b0, 8'h00}) begin
                bad++;
                $display("FAIL reset_idle c=%0d got gnt=%b winc=%b busy=%b wdata=%h want 0000/0/0/00", c, obs_gnt, obs_winc, obs_busy, obs_wdata);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [DSIZE-1:0] d [NREQ][8];
        logic [NREQ-1:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < 8; j++) begin
                d[i][j] = DSIZE'($urandom);
                push(i, d[i][j], 1'b0);
            end
        for (int c = 0; c < 25; c++) begin
            step();
            total++;
            if ({obs_busy, obs_gnt, obs_winc, obs_wdata} !== {exp_busy, exp_gnt, exp_winc, exp_wdata}) begin
                bad++;
                $display("FAIL rr_cycle c=%0d got %b/%b/%b/%h want %b/%b/%b/%h", c, obs_busy, obs_gnt, obs_winc, obs_wdata, exp_busy, exp_gnt, exp_winc, exp_wdata);
            end
        end
        total++;
        if (gq.size() != 5 || nwr != 20) begin
            bad++;
            $display("FAIL rr_counts got grants=%0d writes=%0d want 5/20", gq.size(), nwr);
        end
        for (int g = 0; g < 5 && g < gq.size(); g++) begin
            total++;
            if (gq[g] !== exp_order[g]) begin
                bad++;
                $display("FAIL rr_order g=%0d got %b want %b", g, gq[g], exp_order[g]);
            end
        end
        for (int k = 0; k < 20 && k < wq.size(); k++) begin
            total++;
            if (wq[k] !== d[(k / 4) % 4][(k / 16) * 4 + k % 4]) begin
                bad++;
                $display("FAIL rr_data k=%0d got %h want %h", k, wq[k], d[(k / 4) % 4][(k / 16) * 4 + k % 4]);
            end
        end
    endtask

    task automatic test_last_marker();
        logic [DSIZE-1:0] d0, d1;
        do_reset();
        d0 = DSIZE'($urandom); d1 = DSIZE'($urandom);
        push(2, d0, 1'b0); push(2, d1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if ({obs_busy, obs_gnt, obs_winc, obs_wdata} !== {exp_busy, exp_gnt, exp_winc, exp_wdata}) begin
                bad++;
                $display("FAIL last_cycle c=%0d got %b/%b/%b/%h want %b/%b/%b/%h", c, obs_busy, obs_gnt, obs_winc, obs_wdata, exp_busy, exp_gnt, exp_winc, exp_wdata);
            end
        end
        total++;
        if (nwr != 2 || wq.size() != 2 || wq[0] !== d0 || wq[1] !== d1) begin
            bad++;
            $display("FAIL last_words got n=%0d want 2 words %h %h", nwr, d0, d1);
        end
        push(0, DSIZE'($urandom), 1'b1); push(3, DSIZE'($urandom), 1'b1);
        for (int c = 0; c < 8; c++) step();
        total++;
        if (gq.size() != 3 || gq[1] !== 4'b1000 || gq[2] !== 4'b0001) begin
            bad++;
            $display("FAIL last_ptr got grants=%0d second=%b third=%b want 3/1000/0001", gq.size(), gq.size() > 1 ? gq[1] : 4'bx, gq.size() > 2 ? gq[2] : 4'bx);
        end
    endtask

    task automatic test_full_stall();
        logic [DSIZE-1:0] d [4];
        int guard;
        do_reset();
        for (int j = 0; j < 4; j++) begin d[j] = DSIZE'($urandom); push(1, d[j], 1'b0); end
        guard = 0;
        while (nwr < 1 && guard < 10) begin step(); guard++; end
        total++;
        if (nwr != 1) begin
            bad++;
            $display("FAIL stall_first got writes=%0d want 1", nwr);
        end
        wfull = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (obs_winc !== 1'b0 || obs_gnt !== 4'b0010 || obs_busy !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold c=%0d got winc=%b gnt=%b busy=%b want 0/0010/1", c, obs_winc, obs_gnt, obs_busy);
            end
        end
        wfull = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            total++;
            if ({obs_busy, obs_gnt, obs_winc, obs_wdata} !== {exp_busy, exp_gnt, exp_winc, exp_wdata}) begin
                bad++;
                $display("FAIL stall_cycle c=%0d got %b/%b/%b/%h want %b/%b/%b/%h", c, obs_busy, obs_gnt, obs_winc, obs_wdata, exp_busy, exp_gnt, exp_winc, exp_wdata);
            end
        end
        total++;
        if (nwr != 4 || wq.size() != 4) begin
            bad++;
            $display("FAIL stall_count got writes=%0d want 4", nwr);
        end
        for (int k = 0; k < 4 && k < wq.size(); k++) begin
            total++;
            if (wq[k] !== d[k]) begin
                bad++;
                $display("FAIL stall_data k=%0d got %h want %h", k, wq[k], d[k]);
            end
        end
    endtask

    task automatic test_almost_full();
        do_reset();
        push(1, DSIZE'($urandom), 1'b1);
        wfull_almost = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (obs_gnt !== 4'b0000 || obs_busy !== 1'b0) begin
                bad++;
                $display("FAIL almost_block c=%0d got gnt=%b busy=%b want 0000/0", c, obs_gnt, obs_busy);
            end
        end
        wfull_almost = 1'b0;
        step();
        step();
        total++;
        if (obs_gnt !== 4'b0010 || obs_winc !== 1'b1) begin
            bad++;
            $display("FAIL almost_release got gnt=%b winc=%b want 0010/1", obs_gnt, obs_winc);
        end
        for (int c = 0; c < 3; c++) step();
    endtask

    task automatic test_reset_mid_burst();
        int guard;
        do_reset();
        push(1, DSIZE'($urandom), 1'b1);
        for (int c = 0; c < 4; c++) step();
        for (int j = 0; j < 6; j++) push(2, DSIZE'($urandom), 1'b0);
        guard = 0;
        while (nwr < 3 && guard < 12) begin step(); guard++; end
        total++;
        if (nwr != 3 || obs_gnt !== 4'b0100) begin
            bad++;
            $display("FAIL rstmid_setup got writes=%0d gnt=%b want 3/0100", nwr, obs_gnt);
        end
        wrst_n = 1'b0;
        #1;
        total++;
        if (gnt !== 4'b0000 || winc !== 1'b0 || busy !== 1'b0 || wdata !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_async got gnt=%b winc=%b busy=%b wdata=%h want 0000/0/0/00", gnt, winc, busy, wdata);
        end
        model_reset();
        gq.delete();
        push(0, DSIZE'($urandom), 1'b1);
        push(3, DSIZE'($urandom), 1'b1);
        @(negedge wclk);
        wrst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            total++;
            if ({obs_busy, obs_gnt, obs_winc, obs_wdata} !== {exp_busy, exp_gnt, exp_winc, exp_wdata}) begin
                bad++;
                $display("FAIL rstmid_cycle c=%0d got %b/%b/%b/%h want %b/%b/%b/%h", c, obs_busy, obs_gnt, obs_winc, obs_wdata, exp_busy, exp_gnt, exp_winc, exp_wdata);
            end
        end
        total++;
        if (gq.size() < 1 || gq[0] !== 4'b0001) begin
            bad++;
            $display("FAIL rstmid_prio got first grant=%b want 0001", gq.size() > 0 ? gq[0] : 4'bx);
        end
    endtask

    task automatic test_random();
        int n, guard;
        do_reset();
        n = 0;
        for (int i = 0; i < NREQ; i++) begin
            int len = $urandom_range(10, 25);
            for (int j = 0; j < len; j++) push(i, DSIZE'($urandom), ($urandom % 5) == 0);
            n += len;
        end
        for (int c = 0; c < 300; c++) begin
            wfull = ($urandom % 4) == 0;
            wfull_almost = ($urandom % 4) == 0;
            step();
            total++;
            if ({obs_busy, obs_gnt, obs_winc, obs_wdata} !== {exp_busy, exp_gnt, exp_winc, exp_wdata}) begin
                bad++;
                $display("FAIL rand_cycle c=%0d got %b/%b/%b/%h want %b/%b/%b/%h", c, obs_busy, obs_gnt, obs_winc, obs_wdata, exp_busy, exp_gnt, exp_winc, exp_wdata);
            end
        end
        wfull = 1'b0;
        wfull_almost = 1'b0;
        guard = 0;
        while ((any_pending() || m_busy) && guard < 400) begin
            step();
            guard++;
            total++;
            if ({obs_busy, obs_gnt, obs_winc, obs_wdata} !== {exp_busy, exp_gnt, exp_winc, exp_wdata}) begin
                bad++;
                $display("FAIL rand_drain got %b/%b/%b/%h want %b/%b/%b/%h", obs_busy, obs_gnt, obs_winc, obs_wdata, exp_busy, exp_gnt, exp_winc, exp_wdata);
            end
        end
        total++;
        if (guard >= 400 || nwr != n) begin
            bad++;
            $display("FAIL rand_total got writes=%0d want %0d (drain cycles %0d)", nwr, n, guard);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_last_marker();
        test_full_stall();
        test_almost_full();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
